// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bundle: next-PC loop, redirect, imem request/response and decode handoff.
// master = fetch unit side, slave = surrounding pipeline / memory side.
interface pc_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] program_counter;
    logic [ADDR_W-1:0] program_counter_next;
    logic              flush;
    logic [ADDR_W-1:0] flush_pc;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [DATA_W-1:0] imem_rsp_data;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic              fetch_fault;

    modport master (
        output program_counter, imem_req_valid, imem_req_addr,
        output instr_valid, instr_data, instr_pc, fetch_fault,
        input  program_counter_next, flush, flush_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
    );

    modport slave (
        input  program_counter, imem_req_valid, imem_req_addr,
        input  instr_valid, instr_data, instr_pc, fetch_fault,
        output program_counter_next, flush, flush_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding imem fetch with valid/ready handoff to decode.
// Optional misaligned-PC fault trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    pc_fetch_unit_if.master  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] ALIGN_MASK = '0;
`else
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(3);
`endif

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] stale_q, stale_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] instr_data_q, instr_data_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;

    logic [ADDR_W-1:0] flush_tgt, next_tgt;
    logic              flush_bad, next_bad, pc_bad;

    assign flush_tgt = bus.flush_pc & ~ALIGN_MASK;
    assign next_tgt  = bus.program_counter_next & ~ALIGN_MASK;
    assign flush_bad = |flush_tgt[1:0];
    assign next_bad  = |next_tgt[1:0];
    assign pc_bad    = |pc_q[1:0];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        stale_d      = stale_q;
        pend_d       = pend_q;
        instr_data_d = instr_data_q;
        instr_pc_d   = instr_pc_q;
        if (bus.flush) pc_d = flush_tgt;
        unique case (state_q)
            S_IDLE: begin
                if (bus.flush) state_d = flush_bad ? S_FAULT : S_REQ;
                else           state_d = pc_bad ? S_FAULT : S_REQ;
            end
            S_REQ: begin
                // A stalled request keeps its address after a redirect
                if (bus.flush && !pend_q && !bus.imem_req_ready) begin
                    pend_d  = 1'b1;
                    stale_d = pc_q;
                end
                if (bus.imem_req_ready) begin
                    pend_d  = 1'b0;
                    state_d = (bus.flush || pend_q) ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid && !bus.flush) begin
                    instr_data_d = bus.imem_rsp_data;
                    instr_pc_d   = pc_q;
                    state_d      = S_HOLD;
                end else if (bus.imem_rsp_valid) begin
                    state_d = flush_bad ? S_FAULT : S_REQ;
                end else if (bus.flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (bus.flush) begin
                    state_d = flush_bad ? S_FAULT : S_REQ;
                end else if (bus.instr_ready) begin
                    pc_d    = next_tgt;
                    state_d = next_bad ? S_FAULT : S_REQ;
                end
            end
            S_DRAIN: begin
                if (bus.imem_rsp_valid) begin
                    if (bus.flush) state_d = flush_bad ? S_FAULT : S_REQ;
                    else           state_d = pc_bad ? S_FAULT : S_REQ;
                end
            end
            S_FAULT: begin
                if (bus.flush && !flush_bad) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            stale_q      <= '0;
            pend_q       <= 1'b0;
            instr_data_q <= '0;
            instr_pc_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            stale_q      <= stale_d;
            pend_q       <= pend_d;
            instr_data_q <= instr_data_d;
            instr_pc_q   <= instr_pc_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic fault_q, fault_d;

    assign fault_d = (state_d == S_FAULT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) fault_q <= 1'b0;
        else       fault_q <= fault_d;
    end

    assign bus.fetch_fault = fault_q;
`else
    assign bus.fetch_fault = 1'b0;
`endif

    assign bus.program_counter = pc_q;
    assign bus.imem_req_valid  = (state_q == S_REQ);
    assign bus.imem_req_addr   = pend_q ? stale_q : pc_q;
    assign bus.instr_valid     = (state_q == S_HOLD);
    assign bus.instr_data      = instr_data_q;
    assign bus.instr_pc        = instr_pc_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: reset, streaming fetch, decode stall,
// imem stall with redirect, flush-vs-accept, alignment handling, reset mid-flight.
module tb_pc_fetch_unit;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    pc_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    pc_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // From S_REQ: request accepted, response returned one cycle later
    task automatic fetch(input logic [31:0] data);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = data;
        tick();
        bus.imem_rsp_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.program_counter_next = '0;
        bus.flush          = 1'b0;
        bus.flush_pc       = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.instr_ready    = 1'b0;
        tick();
        tick();
        chk("rst_pc", bus.program_counter, 32'h0);
        chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
        chk("rst_instr_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("rst_instr_data", bus.instr_data, 32'h0);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);
        chk("rst_fault", {31'b0, bus.fetch_fault}, 32'h0);

        reset = 1'b0;
        tick();
        chk("req_after_rst", {31'b0, bus.imem_req_valid}, 32'h1);
        chk("addr_after_rst", bus.imem_req_addr, 32'h0);

        bus.instr_ready = 1'b1;
        fetch(32'hA0);
        chk("s0_valid", {31'b0, bus.instr_valid}, 32'h1);
        chk("s0_pc", bus.instr_pc, 32'h0);
        chk("s0_data", bus.instr_data, 32'hA0);
        bus.program_counter_next = 32'h4;
        tick();
        chk("s1_req_addr", bus.imem_req_addr, 32'h4);
        chk("s1_valid_drop", {31'b0, bus.instr_valid}, 32'h0);
        fetch(32'hA4);
        chk("s1_pc", bus.instr_pc, 32'h4);
        chk("s1_data", bus.instr_data, 32'hA4);
        bus.program_counter_next = 32'h8;
        tick();
        bus.instr_ready = 1'b0;
        fetch(32'hA8);
        chk("s2_pc", bus.instr_pc, 32'h8);

        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", {31'b0, bus.instr_valid}, 32'h1);
            chk("hold_data", bus.instr_data, 32'hA8);
            chk("hold_pc", bus.instr_pc, 32'h8);
            chk("hold_no_req", {31'b0, bus.imem_req_valid}, 32'h0);
        end

        bus.instr_ready = 1'b1;
        bus.program_counter_next = 32'hC;
        bus.imem_req_ready = 1'b0;
        tick();
        bus.instr_ready = 1'b0;
        chk("stall_req0", {31'b0, bus.imem_req_valid}, 32'h1);
        chk("stall_addr0", bus.imem_req_addr, 32'hC);
        tick();
        chk("stall_addr1", bus.imem_req_addr, 32'hC);
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h100;
        tick();
        bus.flush = 1'b0;
        chk("stall_addr2_stale", bus.imem_req_addr, 32'hC);
        chk("stall_req2", {31'b0, bus.imem_req_valid}, 32'h1);
        chk("stall_pc_redirect", bus.program_counter, 32'h100);
        tick();
        chk("stall_addr3_stale", bus.imem_req_addr, 32'hC);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        chk("drain_no_req", {31'b0, bus.imem_req_valid}, 32'h0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD;
        tick();
        bus.imem_rsp_valid = 1'b0;
        chk("drain_no_instr", {31'b0, bus.instr_valid}, 32'h0);
        chk("redirect_addr", bus.imem_req_addr, 32'h100);
        fetch(32'h1100);
        chk("redirect_pc", bus.instr_pc, 32'h100);
        chk("redirect_data", bus.instr_data, 32'h1100);

        bus.flush        = 1'b1;
        bus.flush_pc     = 32'h80;
        bus.instr_ready  = 1'b1;
        bus.program_counter_next = 32'h20;
        tick();
        bus.flush       = 1'b0;
        bus.instr_ready = 1'b0;
        chk("flush_wins_addr", bus.imem_req_addr, 32'h80);
        chk("flush_wins_valid", {31'b0, bus.instr_valid}, 32'h0);

        bus.imem_req_ready = 1'b1;
        tick();
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h200;
        tick();
        bus.flush = 1'b0;
        chk("wait_flush_drain", {31'b0, bus.imem_req_valid}, 32'h0);
        bus.imem_rsp_valid = 1'b1;
        tick();
        bus.imem_rsp_valid = 1'b0;
        chk("wait_flush_addr", bus.imem_req_addr, 32'h200);
        fetch(32'h2200);
        chk("wait_flush_pc", bus.instr_pc, 32'h200);
        chk("wait_flush_data", bus.instr_data, 32'h2200);

        bus.imem_req_ready = 1'b0;
        bus.instr_ready = 1'b1;
        bus.program_counter_next = 32'h22;
        tick();
        bus.instr_ready = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        chk("misalign_fault", {31'b0, bus.fetch_fault}, 32'h1);
        chk("misalign_no_req", {31'b0, bus.imem_req_valid}, 32'h0);
        tick();
        chk("fault_sticky", {31'b0, bus.fetch_fault}, 32'h1);
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h40;
        tick();
        bus.flush = 1'b0;
        chk("fault_clear", {31'b0, bus.fetch_fault}, 32'h0);
        chk("fault_exit_addr", bus.imem_req_addr, 32'h40);
`else
        chk("align_forced_addr", bus.imem_req_addr, 32'h20);
        chk("align_no_fault", {31'b0, bus.fetch_fault}, 32'h0);
        chk("align_req", {31'b0, bus.imem_req_valid}, 32'h1);
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h43;
        tick();
        bus.flush = 1'b0;
        chk("align_stale_addr", bus.imem_req_addr, 32'h20);
`endif
        chk("flush_pc_loaded", bus.program_counter, 32'h40);

        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_pc", bus.program_counter, 32'h0);
        chk("async_rst_req", {31'b0, bus.imem_req_valid}, 32'h0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hBAD;
        tick();
        reset = 1'b0;
        tick();
        bus.imem_rsp_valid = 1'b0;
        chk("post_rst_req", {31'b0, bus.imem_req_valid}, 32'h1);
        chk("post_rst_addr", bus.imem_req_addr, 32'h0);
        chk("post_rst_no_instr", {31'b0, bus.instr_valid}, 32'h0);
        chk("post_rst_data", bus.instr_data, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
